mux_rr_arbiter: RTL



---
 rtl/mux_rr_arbiter_if.sv | 26 ++
 rtl/mux_rr_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Request/data bundle between four requesters and the shared mux arbiter.
interface mux_rr_arbiter_if #(
  parameter int unsigned DATA_W = 2
);
  logic [3:0]        req;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [3:0]        grant;
  logic [1:0]        select;
  logic [DATA_W-1:0] out;
  logic              out_valid;

  // Requester side: drives requests and data, observes grant and mux result.
  modport master (
    output req, in0, in1, in2, in3,
    input  grant, select, out, out_valid
  );

  // Arbiter side.
  modport slave (
    input  req, in0, in1, in2, in3,
    output grant, select, out, out_valid
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux, with a per-grant hold
// limit and a registered mux output plus valid flag.
module mux_rr_arbiter #(
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst_n,
  mux_rr_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state, state_n;
  logic [3:0]        grant_q, grant_n;
  logic [1:0]        select_q, select_n;
  logic [1:0]        last_q, last_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;

  logic [1:0]        win;
  logic              any_req;
  logic              release_now;
  logic [DATA_W-1:0] mux_data;

  // First set request bit scanning upward from the index after the last winner.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic       found;
    pick  = l;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = l + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Winner search and release condition for the current cycle.
  always_comb begin
    win         = pick(bus.req, last_q);
    any_req     = |bus.req;
    release_now = !bus.req[select_q] || (cnt_q == CNT_MAX);
  end

  // Mux selection of the granted requester's data.
  always_comb begin
    mux_data = '0;
    unique case (select_q)
      2'd0: mux_data = bus.in0;
      2'd1: mux_data = bus.in1;
      2'd2: mux_data = bus.in2;
      2'd3: mux_data = bus.in3;
      default: mux_data = '0;
    endcase
  end

  // Next-state logic: grant on request, hold until release, hand off back-to-back.
  always_comb begin
    state_n  = state;
    grant_n  = grant_q;
    select_n = select_q;
    last_n   = last_q;
    cnt_n    = cnt_q;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n  = BUSY;
          grant_n  = 4'b0001 << win;
          select_n = win;
          last_n   = win;
          cnt_n    = '0;
        end
      end
      BUSY: begin
        if (!release_now) begin
          cnt_n = cnt_q + 1'b1;
        end else if (any_req) begin
          grant_n  = 4'b0001 << win;
          select_n = win;
          last_n   = win;
          cnt_n    = '0;
        end else begin
          state_n = IDLE;
          grant_n = '0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // State, arbitration and data registers; last resets to 3 so requester 0 leads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_q     <= '0;
      select_q    <= '0;
      last_q      <= 2'd3;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      grant_q     <= grant_n;
      select_q    <= select_n;
      last_q      <= last_n;
      cnt_q       <= cnt_n;
      out_valid_q <= (state == BUSY);
      if (state == BUSY) begin
        out_q <= mux_data;
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.select    = select_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule
